// File: rtl/ulaplus_palette_pkg.sv
// Shared types, sizes and the default-colour helper for the ULA+ palette store.
package ulaplus_palette_pkg;

  localparam int unsigned PALETTE_DEPTH = 64;
  localparam int unsigned PALETTE_AW    = 6;

  // One palette entry as stored in RAM and driven on rgb: GGGRRRBB.
  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [1:0] b;
  } palette_rgb_t;

  // Power-up initialisation sequencer states (used only when init is built in).
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_t;

  // Default colour of an entry depends only on its low three index bits:
  // each set bit selects the bright level of its channel.
  function automatic palette_rgb_t palette_default(input logic [2:0] colour);
    palette_rgb_t c;
    c.g = colour[2] ? 3'b101 : 3'b000;
    c.r = colour[1] ? 3'b101 : 3'b000;
    c.b = colour[0] ? 2'b10  : 2'b00;
    return c;
  endfunction

endpackage

// File: rtl/ulaplus_palette_ram.sv
// 64 x 8 single-port palette RAM, synchronous write and 1-cycle synchronous read.
// The one read port steers its data into a video or a CPU output register, so
// a CPU access never disturbs the last colour handed to the video path.
module ulaplus_palette_ram
  import ulaplus_palette_pkg::*;
(
  input  logic                  clk28,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic                  to_cpu,
  input  logic [PALETTE_AW-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            vid_rdata,
  output logic [7:0]            cpu_rdata
);

  logic [7:0] mem_q [PALETTE_DEPTH];
  logic [7:0] vid_rdata_q, vid_rdata_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;

  // Array write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk28) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Route a read to the requester's output register; the other one holds.
  always_comb begin
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    if (en && !we) begin
      if (to_cpu) begin
        cpu_rdata_d = mem_q[addr];
      end else begin
        vid_rdata_d = mem_q[addr];
      end
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // Read data registers.
  always_ff @(posedge clk28) begin
    if (rst) begin
      vid_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign vid_rdata = vid_rdata_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: rtl/ulaplus_palette.sv
// ULA+ palette store: CPU request capture, video-priority RAM arbiter with a
// bounded CPU starve limit, and optional power-up colour initialisation.
// Optional feature macro: ULAPLUS_PALETTE_INIT_EN (reset loads default colours).
module ulaplus_palette
  import ulaplus_palette_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       read_req,
  input  logic       write_req,
  input  logic [5:0] rw_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] d_out,
  output logic       d_out_active,
  input  logic       pix_valid,
  input  logic [5:0] pix_index,
  output logic [7:0] rgb,
  output logic       rgb_valid,
  output logic       busy
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic            rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic            pend_q, pend_d, pend_wr_q, pend_wr_d;
  logic [5:0]      pend_addr_q, pend_addr_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rgb_valid_q, rgb_valid_d;
  logic            d_out_active_q, d_out_active_d;

  logic            rd_edge_s, wr_edge_s, pend_live_s, cpu_go_s, vid_go_s;
  logic            run_s, init_wr_s;
  logic [5:0]      init_addr_s;
  logic            ram_en_s, ram_we_s, ram_to_cpu_s;
  logic [5:0]      ram_addr_s;
  logic [7:0]      ram_wdata_s;

`ifdef ULAPLUS_PALETTE_INIT_EN
  init_state_t     state_q, state_d;
  logic [5:0]      init_addr_q, init_addr_d;
  logic            busy_q, busy_d;

  // Init sequencer: one default-colour write per cycle, then run forever.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + 6'd1;
        if (init_addr_q == 6'(PALETTE_DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = 6'd0;
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  // Init sequencer registers; any reset restarts the fill from entry 0.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= 6'd0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign run_s       = (state_q == ST_RUN);
  assign init_wr_s   = (state_q == ST_INIT);
  assign init_addr_s = init_addr_q;
  assign busy        = busy_q;
`else
  assign run_s       = 1'b1;
  assign init_wr_s   = 1'b0;
  assign init_addr_s = 6'd0;
  assign busy        = 1'b0;
`endif

  // Capture, arbitration, starve counting and RAM port selection.
  always_comb begin
    rd_edge_s   = read_req && !rd_prev_q;
    wr_edge_s   = write_req && !wr_prev_q;
    // A pending read dies as soon as the CPU abandons its IO cycle.
    pend_live_s = pend_q && (pend_wr_q || read_req);
    cpu_go_s    = run_s && pend_live_s && (!pix_valid || (starve_q == STARVE_LIM));
    vid_go_s    = run_s && pix_valid && !cpu_go_s;

    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_to_cpu_s = 1'b0;
    ram_addr_s   = pix_index;
    ram_wdata_s  = pend_data_q;
    if (init_wr_s) begin
      ram_en_s    = 1'b1;
      ram_we_s    = 1'b1;
      ram_addr_s  = init_addr_s;
      ram_wdata_s = palette_default(init_addr_s[2:0]);
    end else if (cpu_go_s) begin
      ram_en_s     = 1'b1;
      ram_we_s     = pend_wr_q;
      ram_to_cpu_s = 1'b1;
      ram_addr_s   = pend_addr_q;
    end else if (vid_go_s) begin
      ram_en_s = 1'b1;
    end else begin
      ram_en_s = 1'b0;
    end

    rd_prev_d   = read_req;
    wr_prev_d   = write_req;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    // Newest edge always replaces whatever is pending; write beats a read edge.
    if (wr_edge_s || rd_edge_s) begin
      pend_d      = 1'b1;
      pend_wr_d   = wr_edge_s;
      pend_addr_d = rw_addr;
      pend_data_d = wr_data;
    end else if (cpu_go_s || (pend_q && !pend_live_s)) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (cpu_go_s || !pend_live_s) begin
      starve_d = {SW{1'b0}};
    end else if (vid_go_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end

    // A preempted pixel cycle still reports valid; the RAM keeps the old colour.
    rgb_valid_d = run_s && pix_valid;

    if (cpu_go_s && !pend_wr_q) begin
      d_out_active_d = 1'b1;
    end else if (!read_req) begin
      d_out_active_d = 1'b0;
    end else begin
      d_out_active_d = d_out_active_q;
    end
  end

  // Request, arbiter and output-flag registers.
  always_ff @(posedge clk28) begin
    if (rst) begin
      rd_prev_q      <= 1'b0;
      wr_prev_q      <= 1'b0;
      pend_q         <= 1'b0;
      pend_wr_q      <= 1'b0;
      pend_addr_q    <= 6'd0;
      pend_data_q    <= 8'h00;
      starve_q       <= {SW{1'b0}};
      rgb_valid_q    <= 1'b0;
      d_out_active_q <= 1'b0;
    end else begin
      rd_prev_q      <= rd_prev_d;
      wr_prev_q      <= wr_prev_d;
      pend_q         <= pend_d;
      pend_wr_q      <= pend_wr_d;
      pend_addr_q    <= pend_addr_d;
      pend_data_q    <= pend_data_d;
      starve_q       <= starve_d;
      rgb_valid_q    <= rgb_valid_d;
      d_out_active_q <= d_out_active_d;
    end
  end

  ulaplus_palette_ram u_ram (
    .clk28     (clk28),
    .rst       (rst),
    .en        (ram_en_s),
    .we        (ram_we_s),
    .to_cpu    (ram_to_cpu_s),
    .addr      (ram_addr_s),
    .wdata     (ram_wdata_s),
    .vid_rdata (rgb),
    .cpu_rdata (d_out)
  );

  assign rgb_valid    = rgb_valid_q;
  assign d_out_active = d_out_active_q;

endmodule

// File: tb/tb_ulaplus_palette.sv
// Self-checking bench for ulaplus_palette: vector table plus streamed corner cases,
// with a scoreboard of expected rgb and d_out values consumed by a monitor.
module tb_ulaplus_palette;

  localparam int STARVE_MAX = 4;
  localparam logic [1:0] OP_W = 2'd0, OP_R = 2'd1, OP_V = 2'd2;
`ifdef ULAPLUS_PALETTE_INIT_EN
  localparam logic EXP_BUSY_RST = 1'b1;
  localparam logic [7:0] EXP_ENTRY9 = 8'h02;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
  localparam logic [7:0] EXP_ENTRY9 = 8'h66;
`endif

  typedef struct {
    logic [1:0] op;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  logic       clk28 = 1'b0;
  logic       rst, read_req, write_req, pix_valid;
  logic [5:0] rw_addr, pix_index;
  logic [7:0] wr_data, d_out, rgb;
  logic       d_out_active, rgb_valid, busy;

  int total = 0;
  int bad = 0;
  logic [7:0] mdl [64];
  logic [7:0] rgb_exp_q [$];
  logic [7:0] rd_exp_q [$];
  logic [7:0] last_rgb = 8'h00;
  logic       mon_act_prev = 1'b0;
  logic [7:0] mon_exp;
  vec_t       vecs [13];

  ulaplus_palette #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk28(clk28), .rst(rst), .read_req(read_req), .write_req(write_req),
    .rw_addr(rw_addr), .wr_data(wr_data), .d_out(d_out), .d_out_active(d_out_active),
    .pix_valid(pix_valid), .pix_index(pix_index), .rgb(rgb), .rgb_valid(rgb_valid),
    .busy(busy)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  // Monitor: every rgb_valid and every d_out_active rise consumes one expectation.
  always @(posedge clk28) begin
    #2;
    if (rgb_valid) begin
      if (rgb_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rgb_unexpected: got rgb_valid=1 with rgb %0h, want none", rgb);
      end else begin
        mon_exp = rgb_exp_q.pop_front();
        chk("rgb", rgb, mon_exp);
      end
    end
    if (d_out_active && !mon_act_prev) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_out_unexpected: got d_out_active rise d_out %0h, want none", d_out);
      end else begin
        mon_exp = rd_exp_q.pop_front();
        chk("d_out", d_out, mon_exp);
      end
    end
    mon_act_prev = d_out_active;
  end

  task automatic do_reset();
    rst = 1'b1; read_req = 1'b0; write_req = 1'b0; pix_valid = 1'b0;
    rw_addr = 6'd0; pix_index = 6'd0; wr_data = 8'h00;
    step(); step();
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_d_out_active", d_out_active, 1'b0);
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_rgb_valid", rgb_valid, 1'b0);
    chk("rst_busy", busy, EXP_BUSY_RST);
    rst = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin step(); n++; end
  endtask

  task automatic wr_op(input logic [5:0] a, input logic [7:0] d);
    write_req = 1'b1; rw_addr = a; wr_data = d;
    mdl[a] = d;
    step(); step(); step();
    write_req = 1'b0;
    step(); step();
  endtask

  task automatic rd_op(input logic [5:0] a, input logic [7:0] e);
    int n = 0;
    rd_exp_q.push_back(e);
    rw_addr = a; read_req = 1'b1;
    while (!d_out_active && n < 20) begin step(); n++; end
    chk("rd_latency", n, 2);
    step();
    read_req = 1'b0;
    step();
    chk("rd_act_fall", d_out_active, 1'b0);
    chk("rd_d_out_hold", d_out, e);
    step();
  endtask

  task automatic vid_op(input logic [5:0] a, input logic [7:0] e);
    pix_valid = 1'b1; pix_index = a;
    rgb_exp_q.push_back(e); last_rgb = e;
    step();
    pix_valid = 1'b0;
    step();
  endtask

  // Continuous video with an optional CPU request raised in cycle 0.
  task automatic stream(input int n, input bit do_rd, input bit rd_hold, input bit do_wr,
                        input logic [5:0] a, input logic [7:0] d);
    bit preempt = do_wr || (do_rd && rd_hold);
    logic [7:0] e;
    for (int c = 0; c < n; c++) begin
      pix_valid = 1'b1;
      pix_index = c[0] ? 6'd5 : 6'd63;
      rw_addr = a; wr_data = d;
      write_req = do_wr && (c == 0);
      read_req = do_rd && ((c == 0) || rd_hold);
      if (c == 0 && do_rd && rd_hold) rd_exp_q.push_back(mdl[a]);
      if (c == 0 && do_wr) mdl[a] = d;
      if (preempt && c == STARVE_MAX + 1) e = last_rgb;
      else e = mdl[pix_index];
      rgb_exp_q.push_back(e); last_rgb = e;
      step();
      chk("stream_d_out_active", d_out_active, do_rd && rd_hold && (c >= STARVE_MAX + 1));
    end
    pix_valid = 1'b0; read_req = 1'b0; write_req = 1'b0;
    step();
    chk("stream_act_fall", d_out_active, 1'b0);
    if (do_rd && rd_hold) chk("stream_d_out_hold", d_out, mdl[a]);
    step();
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0]  = '{OP_W, 6'd5,  8'hE3, 8'h00};
    vecs[1]  = '{OP_R, 6'd5,  8'h00, 8'hE3};
    vecs[2]  = '{OP_V, 6'd5,  8'h00, 8'hE3};
    vecs[3]  = '{OP_W, 6'd63, 8'h1F, 8'h00};
    vecs[4]  = '{OP_R, 6'd63, 8'h00, 8'h1F};
    vecs[5]  = '{OP_W, 6'd1,  8'hA5, 8'h00};
    vecs[6]  = '{OP_V, 6'd1,  8'h00, 8'hA5};
    vecs[7]  = '{OP_R, 6'd1,  8'h00, 8'hA5};
    vecs[8]  = '{OP_W, 6'd1,  8'h5A, 8'h00};
    vecs[9]  = '{OP_R, 6'd1,  8'h00, 8'h5A};
    vecs[10] = '{OP_V, 6'd63, 8'h00, 8'h1F};
    vecs[11] = '{OP_W, 6'd0,  8'h00, 8'h00};
    vecs[12] = '{OP_V, 6'd0,  8'h00, 8'h00};

    do_reset();
`ifdef ULAPLUS_PALETTE_INIT_EN
    wait_idle(n);
    chk("init_len", n, 64);
    vid_op(6'd7, 8'hB6);
    vid_op(6'd2, 8'h14);
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 30; k++) step();
    chk("init_mid_busy", busy, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    wait_idle(n);
    chk("init_restart_len", n, 64);
`endif

    for (int i = 0; i < 13; i++) begin
      case (vecs[i].op)
        OP_W: wr_op(vecs[i].a, vecs[i].d);
        OP_R: rd_op(vecs[i].a, vecs[i].exp);
        OP_V: vid_op(vecs[i].a, vecs[i].exp);
        default: ;
      endcase
    end

    // Starvation: read held under continuous video, serviced after STARVE_MAX pixels.
    stream(10, 1'b1, 1'b1, 1'b0, 6'd63, 8'h00);
    // Cancel: one-cycle read under continuous video never reaches the bus.
    stream(10, 1'b1, 1'b0, 1'b0, 6'd63, 8'h00);
    // Write dropped before service still lands.
    stream(10, 1'b0, 1'b0, 1'b1, 6'd0, 8'h3C);
    rd_op(6'd0, 8'h3C);

    // Simultaneous edges: the write wins and no read data is presented.
    seen = 1'b0;
    read_req = 1'b1; write_req = 1'b1; rw_addr = 6'd2; wr_data = 8'h77;
    mdl[2] = 8'h77;
    for (int k = 0; k < 4; k++) begin step(); seen = seen | d_out_active; end
    read_req = 1'b0; write_req = 1'b0;
    step(); step();
    chk("simul_no_read", seen, 1'b0);
    rd_op(6'd2, 8'h77);

    // Reset behaviour of RAM contents.
    wr_op(6'd9, 8'h66);
    do_reset();
    wait_idle(n);
    rd_op(6'd9, EXP_ENTRY9);

    step(); step();
    chk("rgb_queue_empty", rgb_exp_q.size(), 0);
    chk("rd_queue_empty", rd_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
